uart_comm_mstr_gen: RTL and testbench

UART_COMM_MSTR_GEN -- requirements
Module: uart_comm_mstr_gen

---
 rtl/uart_comm_mstr_gen.sv | 279 +++++++++++++++++++++++++++
 tb/tb_uart_comm_mstr_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_comm_mstr_gen.sv
// Command/response master over a UART link: sends a multi-byte command,
// then collects a fixed number of response bytes or gives up on a timeout.
// uart_tx and uart_rx are simple 8N1 engines with BAUD_DIV clocks per bit.

module uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [9:0]    shift_q;
    logic [3:0]    bitCnt_q;
    logic [BW-1:0] baudCnt_q;
    logic          txing_q;
    logic          done_q;

    // Load a start/data/stop frame on trmt and shift it out LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '1;
            bitCnt_q  <= '0;
            baudCnt_q <= '0;
            txing_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (trmt) begin
                shift_q   <= {1'b1, tx_data, 1'b0};
                bitCnt_q  <= '0;
                baudCnt_q <= '0;
                txing_q   <= 1'b1;
            end else if (txing_q) begin
                if (baudCnt_q == BAUD_LAST) begin
                    baudCnt_q <= '0;
                    shift_q   <= {1'b1, shift_q[9:1]};
                    if (bitCnt_q == 4'd9) begin
                        bitCnt_q <= '0;
                        txing_q  <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        bitCnt_q <= bitCnt_q + 4'd1;
                    end
                end else begin
                    baudCnt_q <= baudCnt_q + BW'(1);
                end
            end
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = done_q;
endmodule

module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);

    logic          rxMeta_q;
    logic          rxSync_q;
    logic [7:0]    shift_q;
    logic [7:0]    rxData_q;
    logic [3:0]    bitCnt_q;
    logic [BW-1:0] baudCnt_q;
    logic          rxing_q;
    logic          rdy_q;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= RX;
            rxSync_q <= rxMeta_q;
        end
    end

    // Sample mid-bit: half a bit after the start edge, then every bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            rxData_q  <= '0;
            bitCnt_q  <= '0;
            baudCnt_q <= '0;
            rxing_q   <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            if (clr_rdy) begin
                rdy_q <= 1'b0;
            end
            if (!rxing_q) begin
                if (!rxSync_q) begin
                    rxing_q   <= 1'b1;
                    baudCnt_q <= HALF_LOAD;
                    bitCnt_q  <= '0;
                end
            end else if (baudCnt_q == '0) begin
                baudCnt_q <= BAUD_LAST;
                shift_q   <= {rxSync_q, shift_q[7:1]};
                if (bitCnt_q == 4'd9) begin
                    rxing_q  <= 1'b0;
                    rxData_q <= shift_q;
                    rdy_q    <= 1'b1;
                end else begin
                    bitCnt_q <= bitCnt_q + 4'd1;
                end
            end else begin
                baudCnt_q <= baudCnt_q - BW'(1);
            end
        end
    end

    assign rx_data = rxData_q;
    assign rdy     = rdy_q;
endmodule

module uart_comm_mstr_gen #(
    parameter int CMD_BYTES   = 3,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 100000,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int BAUD_DIV    = 2604
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RX,
    output logic                    TX,
    input  logic [CMD_BYTES*8-1:0]  cmd,
    input  logic                    send_cmd,
    input  logic                    clr_resp_rdy,
    output logic                    cmd_sent,
    output logic [RESP_BYTES*8-1:0] resp,
    output logic                    resp_rdy,
    output logic                    timeout,
    output logic                    busy
);
    localparam int CW = CMD_BYTES * 8;
    localparam int RW = RESP_BYTES * 8;
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    TX_LAST    = 3'(CMD_BYTES - 1);
    localparam logic [2:0]    RX_LAST    = 3'(RESP_BYTES - 1);

    typedef enum logic [1:0] {IDLE, TX_LOAD, TX_WAIT, RX_WAIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cmd_q;
    logic [2:0]    txCnt_q;
    logic [2:0]    rxCnt_q;
    logic [TW-1:0] timer_q;
    logic          cmdSent_q;
    logic [RW-1:0] resp_q;
    logic          respRdy_q;
    logic          timeout_q;

    logic          trmt;
    logic          txDone;
    logic [7:0]    txData;
    logic [2:0]    byteSel;
    logic          rxRdy;
    logic [7:0]    rxData;

    // Pick the command byte for the current tx count in the configured order
    always_comb begin
        byteSel = MSB_FIRST ? (TX_LAST - txCnt_q) : txCnt_q;
        txData  = 8'(cmd_q >> {byteSel, 3'b000});
    end

    assign trmt = (state_q == TX_LOAD);

    uart_tx #(.BAUD_DIV(BAUD_DIV)) uTx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (txData),
        .TX      (TX),
        .tx_done (txDone)
    );

    // Every byte the receiver presents is taken at once: consumed in RX_WAIT,
    // thrown away in any other state, so rdy never lingers past one cycle.
    uart_rx #(.BAUD_DIV(BAUD_DIV)) uRx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (rxRdy),
        .rx_data (rxData),
        .rdy     (rxRdy)
    );

    // Transaction sequencer with its registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            txCnt_q   <= '0;
            rxCnt_q   <= '0;
            timer_q   <= '0;
            cmdSent_q <= 1'b0;
            resp_q    <= '0;
            respRdy_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cmdSent_q <= 1'b0;
            if (clr_resp_rdy) begin
                respRdy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (send_cmd) begin
                        cmd_q     <= cmd;
                        txCnt_q   <= '0;
                        rxCnt_q   <= '0;
                        respRdy_q <= 1'b0;
                        timeout_q <= 1'b0;
                        state_q   <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (txDone) begin
                        if (txCnt_q >= TX_LAST) begin
                            cmdSent_q <= 1'b1;
                            timer_q   <= '0;
                            state_q   <= RX_WAIT;
                        end else begin
                            txCnt_q <= txCnt_q + 3'd1;
                            state_q <= TX_LOAD;
                        end
                    end
                end
                RX_WAIT: begin
                    if (rxRdy) begin
                        resp_q  <= (resp_q << 8) | RW'(rxData);
                        timer_q <= '0;
                        rxCnt_q <= rxCnt_q + 3'd1;
                        if (rxCnt_q >= RX_LAST) begin
                            respRdy_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else if (timer_q >= TIMER_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_sent = cmdSent_q;
    assign resp     = resp_q;
    assign resp_rdy = respRdy_q;
    assign timeout  = timeout_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_comm_mstr_gen.sv
// Directed bench for uart_comm_mstr_gen: two instances (MSB-first with a
// two-byte response and short timeout, LSB-first with a one-byte response),
// with bench-side UART framing to decode TX and to play the remote end.

module tb_uart_comm_mstr_gen;
    localparam int BD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        rxA   = 1'b1;
    logic        txA;
    logic [23:0] cmdA  = '0;
    logic        sendA = 1'b0;
    logic        clrA  = 1'b0;
    logic        sentA;
    logic [15:0] respA;
    logic        rdyA, toA, busyA;

    logic        rxB   = 1'b1;
    logic        txB;
    logic [23:0] cmdB  = '0;
    logic        sendB = 1'b0;
    logic        clrB  = 1'b0;
    logic        sentB;
    logic [7:0]  respB;
    logic        rdyB, toB, busyB;

    int vecCnt   = 0;
    int errCnt   = 0;
    int sentCntA = 0;
    int sentCntB = 0;
    int busyLowA = 0;
    int busyLowB = 0;

    uart_comm_mstr_gen #(.CMD_BYTES(3), .RESP_BYTES(2), .TIMEOUT_CYC(50),
                         .MSB_FIRST(1'b1), .BAUD_DIV(BD)) dutA (
        .clk(clk), .rst_n(rst_n), .RX(rxA), .TX(txA), .cmd(cmdA),
        .send_cmd(sendA), .clr_resp_rdy(clrA), .cmd_sent(sentA),
        .resp(respA), .resp_rdy(rdyA), .timeout(toA), .busy(busyA)
    );

    uart_comm_mstr_gen #(.CMD_BYTES(3), .RESP_BYTES(1),
                         .MSB_FIRST(1'b0), .BAUD_DIV(BD)) dutB (
        .clk(clk), .rst_n(rst_n), .RX(rxB), .TX(txB), .cmd(cmdB),
        .send_cmd(sendB), .clr_resp_rdy(clrB), .cmd_sent(sentB),
        .resp(respB), .resp_rdy(rdyB), .timeout(toB), .busy(busyB)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Running tallies of cmd_sent pulses and busy-low cycles, read as deltas
    always @(negedge clk) begin
        if (sentA) sentCntA <= sentCntA + 1;
        if (sentB) sentCntB <= sentCntB + 1;
        if (!busyA) busyLowA <= busyLowA + 1;
        if (!busyB) busyLowB <= busyLowB + 1;
    end

    // Last-resort guard in case something upstream hangs the run
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pulseSend(input int which);
        @(negedge clk);
        if (which == 0) sendA = 1'b1; else sendB = 1'b1;
        @(negedge clk);
        if (which == 0) sendA = 1'b0; else sendB = 1'b0;
    endtask

    // Wait for a start bit on the chosen TX, then sample each bit mid-period
    task automatic captureByte(input int which, output logic [7:0] b, output bit ok);
        bit seen;
        seen = 1'b0;
        b    = '0;
        ok   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (((which == 0) ? txA : txB) == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk);
                b[i] = (which == 0) ? txA : txB;
            end
            repeat (BD) @(negedge clk);
            ok = (((which == 0) ? txA : txB) == 1'b1);
        end
    endtask

    // Play the remote end: one 8N1 frame onto the chosen RX line
    task automatic sendByte(input int which, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (which == 0) rxA = frame[i]; else rxB = frame[i];
            repeat (BD) @(negedge clk);
        end
    endtask

    task automatic waitSent(input int which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (((which == 0) ? sentA : sentB) == 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitIdle(input int which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (((which == 0) ? busyA : busyB) == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vecCnt++; if (txA !== 1'b1)    begin errCnt++; $display("[TB] FAIL reset_tx_a: got %b want 1", txA); end
        vecCnt++; if (busyA !== 1'b0)  begin errCnt++; $display("[TB] FAIL reset_busy_a: got %b want 0", busyA); end
        vecCnt++; if (sentA !== 1'b0)  begin errCnt++; $display("[TB] FAIL reset_sent_a: got %b want 0", sentA); end
        vecCnt++; if (respA !== 16'h0) begin errCnt++; $display("[TB] FAIL reset_resp_a: got %h want 0000", respA); end
        vecCnt++; if (rdyA !== 1'b0)   begin errCnt++; $display("[TB] FAIL reset_rdy_a: got %b want 0", rdyA); end
        vecCnt++; if (toA !== 1'b0)    begin errCnt++; $display("[TB] FAIL reset_timeout_a: got %b want 0", toA); end
        vecCnt++; if (txB !== 1'b1)    begin errCnt++; $display("[TB] FAIL reset_tx_b: got %b want 1", txB); end
        vecCnt++; if (busyB !== 1'b0)  begin errCnt++; $display("[TB] FAIL reset_busy_b: got %b want 0", busyB); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_msb_first_response();
        logic [7:0] expBytes [3];
        logic [7:0] b;
        bit ok, gotSent;
        int sentBase, lowBase, lowEnd;
        expBytes = '{8'hA5, 8'h3C, 8'h0F};
        cmdA     = 24'hA53C0F;
        sentBase = sentCntA;
        lowEnd   = 0;
        pulseSend(0);
        lowBase = busyLowA;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    captureByte(0, b, ok);
                    vecCnt++;
                    if (!ok || b !== expBytes[i]) begin
                        errCnt++;
                        $display("[TB] FAIL msb_byte%0d: got %h (frame ok %0d) want %h", i, b, ok, expBytes[i]);
                    end
                end
                lowEnd = busyLowA;
            end
            begin
                waitSent(0, gotSent);
                vecCnt++; if (!gotSent) begin errCnt++; $display("[TB] FAIL msb_cmd_sent: got none want pulse"); end
                if (gotSent) begin
                    sendByte(0, 8'h12);
                    sendByte(0, 8'h34);
                end
            end
        join
        repeat (10) @(negedge clk);
        vecCnt++; if (lowEnd - lowBase != 0)     begin errCnt++; $display("[TB] FAIL msb_busy_hold: got %0d low cycles want 0", lowEnd - lowBase); end
        vecCnt++; if (sentCntA - sentBase != 1)  begin errCnt++; $display("[TB] FAIL msb_sent_count: got %0d want 1", sentCntA - sentBase); end
        vecCnt++; if (respA !== 16'h1234)        begin errCnt++; $display("[TB] FAIL resp_value: got %h want 1234", respA); end
        vecCnt++; if (rdyA !== 1'b1)             begin errCnt++; $display("[TB] FAIL resp_rdy_set: got %b want 1", rdyA); end
        vecCnt++; if (busyA !== 1'b0)            begin errCnt++; $display("[TB] FAIL resp_busy: got %b want 0", busyA); end
        vecCnt++; if (toA !== 1'b0)              begin errCnt++; $display("[TB] FAIL resp_timeout: got %b want 0", toA); end
        @(negedge clk);
        clrA = 1'b1;
        @(negedge clk);
        clrA = 1'b0;
        vecCnt++; if (rdyA !== 1'b0)             begin errCnt++; $display("[TB] FAIL clr_resp_rdy: got %b want 0", rdyA); end
        vecCnt++; if (respA !== 16'h1234)        begin errCnt++; $display("[TB] FAIL resp_hold: got %h want 1234", respA); end
    endtask

    task automatic test_timeout();
        bit gotSent;
        int n;
        cmdA = 24'h010203;
        pulseSend(0);
        waitSent(0, gotSent);
        vecCnt++; if (!gotSent) begin errCnt++; $display("[TB] FAIL to_cmd_sent: got none want pulse"); end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (toA) break;
        end
        vecCnt++; if (n != 50)            begin errCnt++; $display("[TB] FAIL to_latency: got %0d cycles want 50", n); end
        vecCnt++; if (toA !== 1'b1)       begin errCnt++; $display("[TB] FAIL to_flag: got %b want 1", toA); end
        vecCnt++; if (rdyA !== 1'b0)      begin errCnt++; $display("[TB] FAIL to_rdy: got %b want 0", rdyA); end
        vecCnt++; if (busyA !== 1'b0)     begin errCnt++; $display("[TB] FAIL to_busy: got %b want 0", busyA); end
        vecCnt++; if (respA !== 16'h1234) begin errCnt++; $display("[TB] FAIL to_resp_hold: got %h want 1234", respA); end
    endtask

    task automatic test_ignore_busy();
        logic [7:0] expBytes [3];
        logic [7:0] b;
        bit ok, gotSent, gotIdle;
        int sentBase, activity;
        expBytes = '{8'h11, 8'h22, 8'h33};
        cmdA     = 24'h112233;
        sentBase = sentCntA;
        pulseSend(0);
        vecCnt++; if (toA !== 1'b0) begin errCnt++; $display("[TB] FAIL ign_timeout_clr: got %b want 0", toA); end
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    captureByte(0, b, ok);
                    vecCnt++;
                    if (!ok || b !== expBytes[i]) begin
                        errCnt++;
                        $display("[TB] FAIL ign_byte%0d: got %h (frame ok %0d) want %h", i, b, ok, expBytes[i]);
                    end
                end
            end
            begin
                repeat (10) @(negedge clk);
                cmdA  = 24'hFFEEDD;
                sendA = 1'b1;
                @(negedge clk);
                sendA = 1'b0;
                repeat (50) @(negedge clk);
                cmdA  = 24'h445566;
                sendA = 1'b1;
                @(negedge clk);
                sendA = 1'b0;
            end
        join
        waitSent(0, gotSent);
        vecCnt++; if (!gotSent) begin errCnt++; $display("[TB] FAIL ign_cmd_sent: got none want pulse"); end
        waitIdle(0, gotIdle);
        vecCnt++; if (!gotIdle) begin errCnt++; $display("[TB] FAIL ign_idle: still busy want idle"); end
        activity = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txA !== 1'b1 || busyA !== 1'b0) activity++;
        end
        vecCnt++; if (activity != 0)            begin errCnt++; $display("[TB] FAIL ign_no_queue: got %0d active cycles want 0", activity); end
        vecCnt++; if (sentCntA - sentBase != 1) begin errCnt++; $display("[TB] FAIL ign_sent_count: got %0d want 1", sentCntA - sentBase); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] expBytes [3];
        logic [7:0] b;
        bit ok, gotSent;
        int sentBase, lowBase, lowEnd;
        expBytes = '{8'h0F, 8'h3C, 8'hA5};
        cmdB     = 24'hA53C0F;
        sentBase = sentCntB;
        lowEnd   = 0;
        pulseSend(1);
        lowBase = busyLowB;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    captureByte(1, b, ok);
                    vecCnt++;
                    if (!ok || b !== expBytes[i]) begin
                        errCnt++;
                        $display("[TB] FAIL lsb_byte%0d: got %h (frame ok %0d) want %h", i, b, ok, expBytes[i]);
                    end
                end
                lowEnd = busyLowB;
            end
            begin
                waitSent(1, gotSent);
                vecCnt++; if (!gotSent) begin errCnt++; $display("[TB] FAIL lsb_cmd_sent: got none want pulse"); end
                if (gotSent) sendByte(1, 8'h5A);
            end
        join
        repeat (10) @(negedge clk);
        vecCnt++; if (lowEnd - lowBase != 0)    begin errCnt++; $display("[TB] FAIL lsb_busy_hold: got %0d low cycles want 0", lowEnd - lowBase); end
        vecCnt++; if (sentCntB - sentBase != 1) begin errCnt++; $display("[TB] FAIL lsb_sent_count: got %0d want 1", sentCntB - sentBase); end
        vecCnt++; if (respB !== 8'h5A)          begin errCnt++; $display("[TB] FAIL lsb_resp: got %h want 5a", respB); end
        vecCnt++; if (rdyB !== 1'b1)            begin errCnt++; $display("[TB] FAIL lsb_rdy: got %b want 1", rdyB); end
        vecCnt++; if (busyB !== 1'b0)           begin errCnt++; $display("[TB] FAIL lsb_busy: got %b want 0", busyB); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] expBytes [3];
        logic [7:0] b;
        bit ok, gotSent, gotIdle;
        expBytes = '{8'h5A, 8'hA5, 8'h7E};
        cmdA     = 24'hC3_96_69;
        pulseSend(0);
        captureByte(0, b, ok);
        vecCnt++; if (!ok || b !== 8'hC3) begin errCnt++; $display("[TB] FAIL abort_first_byte: got %h want c3", b); end
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecCnt++; if (txA !== 1'b1)    begin errCnt++; $display("[TB] FAIL abort_tx: got %b want 1", txA); end
        vecCnt++; if (busyA !== 1'b0)  begin errCnt++; $display("[TB] FAIL abort_busy: got %b want 0", busyA); end
        vecCnt++; if (respA !== 16'h0) begin errCnt++; $display("[TB] FAIL abort_resp: got %h want 0000", respA); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        cmdA = 24'h5AA57E;
        pulseSend(0);
        for (int i = 0; i < 3; i++) begin
            captureByte(0, b, ok);
            vecCnt++;
            if (!ok || b !== expBytes[i]) begin
                errCnt++;
                $display("[TB] FAIL abort_new_byte%0d: got %h (frame ok %0d) want %h", i, b, ok, expBytes[i]);
            end
        end
        waitSent(0, gotSent);
        vecCnt++; if (!gotSent) begin errCnt++; $display("[TB] FAIL abort_cmd_sent: got none want pulse"); end
        waitIdle(0, gotIdle);
        vecCnt++; if (!gotIdle) begin errCnt++; $display("[TB] FAIL abort_idle: still busy want idle"); end
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] starting uart_comm_mstr_gen directed tests");
        test_reset();
        test_msb_first_response();
        test_timeout();
        test_ignore_busy();
        test_lsb_first();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end
endmodule
